// File: rtl/munoc_axi_quiesce_ctrl.sv
// ---------------------------------------------------------------------------
// munoc_axi_quiesce_ctrl
//   Quiesces an AXI link before isolation. It tracks outstanding writes,
//   outstanding reads and the AW/W-last balance from observed handshakes.
//   When isolation is requested it blocks new address issue, waits for the
//   link to drain, and then closes the isolation gate and acknowledges.
//
// Ports
//   clk, rstnn            clock and asynchronous active-low reset
//   isolate_req           level request to quiesce and isolate the link
//   aw*/w*/b*/ar*/r*      observed AXI handshake signals (inputs only)
//   block_addr            masks new AW/AR issue upstream
//   isolate_gate          block control for the downstream isolation gate
//   isolate_ack           high while the link is isolated
//   num_wr, num_rd        outstanding write / read transaction counts
//   cnt_error             sticky counter overflow/underflow flag
// ---------------------------------------------------------------------------
module munoc_axi_quiesce_ctrl #(
  parameter int BW_CNT = 4
) (
  input  logic              clk,
  input  logic              rstnn,
  input  logic              isolate_req,
  input  logic              awvalid,
  input  logic              awready,
  input  logic              wvalid,
  input  logic              wready,
  input  logic              wlast,
  input  logic              bvalid,
  input  logic              bready,
  input  logic              arvalid,
  input  logic              arready,
  input  logic              rvalid,
  input  logic              rready,
  input  logic              rlast,
  output logic              block_addr,
  output logic              isolate_gate,
  output logic              isolate_ack,
  output logic [BW_CNT-1:0] num_wr,
  output logic [BW_CNT-1:0] num_rd,
  output logic              cnt_error
);

  localparam logic [1:0] S_RUN     = 2'd0;
  localparam logic [1:0] S_DRAIN   = 2'd1;
  localparam logic [1:0] S_ISO     = 2'd2;
  localparam logic [1:0] S_RELEASE = 2'd3;

  localparam logic [BW_CNT-1:0]        CNT_MAX = {BW_CNT{1'b1}};
  localparam logic [BW_CNT-1:0]        CNT_ONE = {{(BW_CNT-1){1'b0}}, 1'b1};
  localparam logic signed [BW_CNT:0]   BAL_MAX = {1'b0, {BW_CNT{1'b1}}};
  localparam logic signed [BW_CNT:0]   BAL_MIN = {1'b1, {BW_CNT{1'b0}}};
  localparam logic signed [BW_CNT:0]   BAL_ONE = {{BW_CNT{1'b0}}, 1'b1};

  logic [1:0]               r_state;
  logic [1:0]               w_state_nxt;
  logic [BW_CNT-1:0]        r_num_wr, r_num_rd;
  logic [BW_CNT-1:0]        w_wr_nxt, w_rd_nxt;
  // AW fires minus W-last fires; W data may legally precede its AW.
  logic signed [BW_CNT:0]   r_w_bal;
  logic signed [BW_CNT:0]   w_bal_nxt;
  logic                     r_cnt_error;
  logic                     w_wr_err, w_rd_err, w_bal_err;
  logic                     w_idle;

  wire w_aw_fire = awvalid & awready;
  wire w_wl_fire = wvalid & wready & wlast;
  wire w_b_fire  = bvalid & bready;
  wire w_ar_fire = arvalid & arready;
  wire w_rl_fire = rvalid & rready & rlast;

  // Counters saturate instead of wrapping; a blocked step raises the error.
  always_comb begin
    w_wr_nxt = r_num_wr;
    w_wr_err = 1'b0;
    if (w_aw_fire && !w_b_fire) begin
      if (r_num_wr == CNT_MAX) w_wr_err = 1'b1;
      else                     w_wr_nxt = r_num_wr + CNT_ONE;
    end else if (!w_aw_fire && w_b_fire) begin
      if (r_num_wr == '0) w_wr_err = 1'b1;
      else                w_wr_nxt = r_num_wr - CNT_ONE;
    end
  end

  always_comb begin
    w_rd_nxt = r_num_rd;
    w_rd_err = 1'b0;
    if (w_ar_fire && !w_rl_fire) begin
      if (r_num_rd == CNT_MAX) w_rd_err = 1'b1;
      else                     w_rd_nxt = r_num_rd + CNT_ONE;
    end else if (!w_ar_fire && w_rl_fire) begin
      if (r_num_rd == '0) w_rd_err = 1'b1;
      else                w_rd_nxt = r_num_rd - CNT_ONE;
    end
  end

  always_comb begin
    w_bal_nxt = r_w_bal;
    w_bal_err = 1'b0;
    if (w_aw_fire && !w_wl_fire) begin
      if (r_w_bal == BAL_MAX) w_bal_err = 1'b1;
      else                    w_bal_nxt = r_w_bal + BAL_ONE;
    end else if (!w_aw_fire && w_wl_fire) begin
      if (r_w_bal == BAL_MIN) w_bal_err = 1'b1;
      else                    w_bal_nxt = r_w_bal - BAL_ONE;
    end
  end

  // Drain completion looks at registered counts only, so a final response
  // handshake moves the FSM to ISOLATED one edge after the counts reach 0.
  assign w_idle = (r_num_wr == '0) && (r_num_rd == '0) && (r_w_bal == '0);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_RUN:     if (isolate_req) w_state_nxt = S_DRAIN;
      S_DRAIN:   if (!isolate_req) w_state_nxt = S_RUN;
                 else if (w_idle)  w_state_nxt = S_ISO;
      S_ISO:     if (!isolate_req) w_state_nxt = S_RELEASE;
      // Gate opens here while addresses stay blocked for one more cycle.
      S_RELEASE: w_state_nxt = S_RUN;
      default:   w_state_nxt = S_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rstnn) begin
    if (!rstnn) begin
      r_state     <= S_RUN;
      r_num_wr    <= '0;
      r_num_rd    <= '0;
      r_w_bal     <= '0;
      r_cnt_error <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_num_wr    <= w_wr_nxt;
      r_num_rd    <= w_rd_nxt;
      r_w_bal     <= w_bal_nxt;
      r_cnt_error <= r_cnt_error | w_wr_err | w_rd_err | w_bal_err;
    end
  end

  // Control outputs decode only the state register: no input-to-output path.
  assign block_addr   = (r_state != S_RUN);
  assign isolate_gate = (r_state == S_ISO);
  assign isolate_ack  = (r_state == S_ISO);
  assign num_wr       = r_num_wr;
  assign num_rd       = r_num_rd;
  assign cnt_error    = r_cnt_error;

endmodule
